// File: rtl/route_sched.sv
// route_sched: round-robin header scheduler feeding one shared XY route stage.
// Optional `RSCHED_LOCAL_PRIO_EN gives port 0 (local) fixed priority.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   req[N]        per-port header request, held until acked
//   hdr_i[N*HW]   packed headers, port i at [i*HW +: HW]
//   ack[N]        one-hot combinational accept pulse
//   out_vld       result valid (held until out_rdy)
//   out_rdy       downstream accepts the result
//   out_src[N]    one-hot source port of the result
//   out_dir[5]    one-hot direction {W,S,E,N,L}
//   out_hdr[HW]   header with the consumed hop removed
module route_sched #(
  parameter int N  = 5,
  parameter int HW = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*HW-1:0] hdr_i,
  output logic [N-1:0]    ack,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [N-1:0]    out_src,
  output logic [4:0]      out_dir,
  output logic [HW-1:0]   out_hdr
);

  localparam int PW = $clog2(N);
  localparam logic [PW:0] NW = (PW+1)'(N);

  localparam logic [4:0] D_L = 5'b00001;
  localparam logic [4:0] D_N = 5'b00010;
  localparam logic [4:0] D_E = 5'b00100;
  localparam logic [4:0] D_S = 5'b01000;
  localparam logic [4:0] D_W = 5'b10000;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] idx;
  logic [PW:0]   sum;
  logic          found;
  logic          load;
  logic          fire;
  logic          adv;
  logic [N-1:0]  gnt_oh;
  logic [HW-1:0] hsel;
  logic [HW-1:0] hnew;
  logic [4:0]    dir;
  logic          ydir;
  logic          xdir;
  logic [7:0]    y;
  logic [7:0]    x;

  assign load = ~out_vld | out_rdy;
  assign fire = load & found & ~rst;

  // Scan ports starting at the pointer, wrapping at N.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    sum   = '0;
    idx   = '0;
`ifdef RSCHED_LOCAL_PRIO_EN
    if (req[0]) begin
      found = 1'b1;
    end
`endif
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= NW) begin
        sum = sum - NW;
      end
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

`ifdef RSCHED_LOCAL_PRIO_EN
  // A local grant leaves the ring pointer untouched.
  assign adv = fire & ~req[0];
`else
  assign adv = fire;
`endif

  assign ptr_nxt = (gnt == PW'(N-1)) ? '0 : gnt + PW'(1);

  always_comb begin
    gnt_oh      = '0;
    gnt_oh[gnt] = 1'b1;
  end

  assign ack = fire ? gnt_oh : '0;

  always_comb begin
    hsel = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == PW'(i)) begin
        hsel = hdr_i[i*HW +: HW];
      end
    end
  end

  assign {ydir, y, xdir, x} = hsel;

  // XY order: exhaust X before Y; only a nonzero field is decremented.
  always_comb begin
    hnew = hsel;
    dir  = D_L;
    if (x != 8'd0) begin
      dir       = xdir ? D_W : D_E;
      hnew[7:0] = x - 8'd1;
    end else if (y != 8'd0) begin
      dir        = ydir ? D_S : D_N;
      hnew[16:9] = y - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_src <= '0;
      out_dir <= '0;
      out_hdr <= '0;
      ptr     <= '0;
    end else begin
      if (load) begin
        out_vld <= fire;
      end
      if (fire) begin
        out_src <= gnt_oh;
        out_dir <= dir;
        out_hdr <= hnew;
      end
      if (adv) begin
        ptr <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_route_sched.sv
// tb_route_sched: directed self-checking bench for route_sched.
// Inputs change on negedge; checks sample #1 later.
module tb_route_sched;

  localparam int N  = 5;
  localparam int HW = 18;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*HW-1:0] hdr;
  logic [N-1:0]    ack;
  logic            out_vld;
  logic            out_rdy;
  logic [N-1:0]    out_src;
  logic [4:0]      out_dir;
  logic [HW-1:0]   out_hdr;

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  route_sched #(.N(N), .HW(HW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .hdr_i   (hdr),
    .ack     (ack),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_src (out_src),
    .out_dir (out_dir),
    .out_hdr (out_hdr)
  );

  function automatic logic [17:0] mk(input logic yd, input logic [7:0] y,
                                     input logic xd, input logic [7:0] x);
    return {yd, y, xd, x};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; out_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 5'b11111; out_rdy = 1'b1;
    for (int p = 0; p < N; p++) hdr[p*HW +: HW] = mk(0, 8'h03, 0, 8'h02);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      nchk++; if (ack !== 5'b0) begin nfail++; $display("FAIL rst_ack got=%b exp=0", ack); end
      nchk++; if (out_vld !== 1'b0) begin nfail++; $display("FAIL rst_vld got=%b exp=0", out_vld); end
      nchk++; if (out_src !== 5'b0 || out_dir !== 5'b0) begin nfail++; $display("FAIL rst_srcdir got=%b/%b exp=0/0", out_src, out_dir); end
      nchk++; if (out_hdr !== 18'h0) begin nfail++; $display("FAIL rst_hdr got=%h exp=0", out_hdr); end
    end
    @(negedge clk); rst = 1'b0; #1;
    nchk++; if (ack !== 5'b00001) begin nfail++; $display("FAIL rst_first_ack got=%b exp=00001", ack); end
    @(negedge clk); req = '0; #1;
    nchk++; if (out_vld !== 1'b1 || out_src !== 5'b00001) begin nfail++; $display("FAIL rst_first_out got=%b/%b exp=1/00001", out_vld, out_src); end
    nchk++; if (out_dir !== 5'b00100 || out_hdr !== mk(0, 8'h03, 0, 8'h01)) begin nfail++; $display("FAIL rst_first_route got=%b/%h exp=00100/%h", out_dir, out_hdr, mk(0, 8'h03, 0, 8'h01)); end
  endtask

  task automatic test_east();
    do_reset();
    @(negedge clk);
    req = 5'b00010; hdr[1*HW +: HW] = mk(0, 8'h03, 0, 8'h02); #1;
    nchk++; if (ack !== 5'b00010) begin nfail++; $display("FAIL east_ack got=%b exp=00010", ack); end
    @(negedge clk); req = '0; #1;
    nchk++; if (out_vld !== 1'b1) begin nfail++; $display("FAIL east_vld got=%b exp=1", out_vld); end
    nchk++; if (out_dir !== 5'b00100) begin nfail++; $display("FAIL east_dir got=%b exp=00100", out_dir); end
    nchk++; if (out_hdr !== mk(0, 8'h03, 0, 8'h01)) begin nfail++; $display("FAIL east_hdr got=%h exp=%h", out_hdr, mk(0, 8'h03, 0, 8'h01)); end
    nchk++; if (out_src !== 5'b00010) begin nfail++; $display("FAIL east_src got=%b exp=00010", out_src); end
    nchk++; if (ack !== 5'b0) begin nfail++; $display("FAIL east_noack got=%b exp=0", ack); end
    @(negedge clk); #1;
    nchk++; if (out_vld !== 1'b0) begin nfail++; $display("FAIL east_drain got=%b exp=0", out_vld); end
  endtask

  // Back-to-back grants across S, L, W and N routes with a moving pointer.
  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    req = 5'b00010; hdr[1*HW +: HW] = mk(1, 8'h01, 1, 8'h00); #1;
    nchk++; if (ack !== 5'b00010) begin nfail++; $display("FAIL b2b_ack1 got=%b exp=00010", ack); end
    @(negedge clk);
    req = 5'b10000; hdr[4*HW +: HW] = mk(1, 8'h00, 1, 8'h00); #1;
    nchk++; if (ack !== 5'b10000) begin nfail++; $display("FAIL b2b_ack4 got=%b exp=10000", ack); end
    nchk++; if (out_vld !== 1'b1 || out_src !== 5'b00010) begin nfail++; $display("FAIL b2b_s_src got=%b/%b exp=1/00010", out_vld, out_src); end
    nchk++; if (out_dir !== 5'b01000 || out_hdr !== mk(1, 8'h00, 1, 8'h00)) begin nfail++; $display("FAIL b2b_s_route got=%b/%h exp=01000/%h", out_dir, out_hdr, mk(1, 8'h00, 1, 8'h00)); end
    @(negedge clk);
    req = 5'b00100; hdr[2*HW +: HW] = mk(0, 8'h00, 1, 8'hFF); #1;
    nchk++; if (ack !== 5'b00100) begin nfail++; $display("FAIL b2b_ack2 got=%b exp=00100", ack); end
    nchk++; if (out_src !== 5'b10000 || out_dir !== 5'b00001) begin nfail++; $display("FAIL b2b_l_route got=%b/%b exp=10000/00001", out_src, out_dir); end
    nchk++; if (out_hdr !== mk(1, 8'h00, 1, 8'h00)) begin nfail++; $display("FAIL b2b_l_hdr got=%h exp=%h", out_hdr, mk(1, 8'h00, 1, 8'h00)); end
    @(negedge clk);
    req = 5'b00001; hdr[0*HW +: HW] = mk(0, 8'h05, 0, 8'h00); #1;
    nchk++; if (ack !== 5'b00001) begin nfail++; $display("FAIL b2b_ack0 got=%b exp=00001", ack); end
    nchk++; if (out_src !== 5'b00100 || out_dir !== 5'b10000) begin nfail++; $display("FAIL b2b_w_route got=%b/%b exp=00100/10000", out_src, out_dir); end
    nchk++; if (out_hdr !== mk(0, 8'h00, 1, 8'hFE)) begin nfail++; $display("FAIL b2b_w_hdr got=%h exp=%h", out_hdr, mk(0, 8'h00, 1, 8'hFE)); end
    @(negedge clk); req = '0; #1;
    nchk++; if (out_src !== 5'b00001 || out_dir !== 5'b00010) begin nfail++; $display("FAIL b2b_n_route got=%b/%b exp=00001/00010", out_src, out_dir); end
    nchk++; if (out_hdr !== mk(0, 8'h04, 0, 8'h00)) begin nfail++; $display("FAIL b2b_n_hdr got=%h exp=%h", out_hdr, mk(0, 8'h04, 0, 8'h00)); end
  endtask

`ifdef RSCHED_LOCAL_PRIO_EN
  task automatic test_local_prio();
    do_reset();
    for (int p = 0; p < N; p++) hdr[p*HW +: HW] = mk(0, 8'h00, 0, 8'h01);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); req = 5'b01001; #1;
      nchk++; if (ack !== 5'b00001) begin nfail++; $display("FAIL prio_ack%0d got=%b exp=00001", c, ack); end
    end
    @(negedge clk); req = 5'b01000; #1;
    nchk++; if (ack !== 5'b01000) begin nfail++; $display("FAIL prio_drop got=%b exp=01000", ack); end
    @(negedge clk); req = '0; #1;
    nchk++; if (out_src !== 5'b01000) begin nfail++; $display("FAIL prio_src got=%b exp=01000", out_src); end
  endtask
`else
  task automatic test_round_robin();
    logic [4:0] e;
    do_reset();
    for (int p = 0; p < N; p++) hdr[p*HW +: HW] = mk(0, 8'h00, 0, 8'h01);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); req = 5'b11111; #1;
      e = 5'b00001 << (c % 5);
      nchk++; if (ack !== e) begin nfail++; $display("FAIL rr_ack%0d got=%b exp=%b", c, ack, e); end
      if (c > 0) begin
        e = 5'b00001 << ((c - 1) % 5);
        nchk++; if (out_vld !== 1'b1 || out_src !== e) begin nfail++; $display("FAIL rr_src%0d got=%b/%b exp=1/%b", c, out_vld, out_src, e); end
      end
    end
    @(negedge clk); req = '0;
  endtask
`endif

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    req = 5'b00010; hdr[1*HW +: HW] = mk(0, 8'h00, 0, 8'h03); #1;
    nchk++; if (ack !== 5'b00010) begin nfail++; $display("FAIL bp_ack1 got=%b exp=00010", ack); end
    @(negedge clk);
    out_rdy = 1'b0; req = 5'b00100; hdr[2*HW +: HW] = mk(0, 8'h02, 0, 8'h00);
    for (int c = 0; c < 4; c++) begin
      #1;
      nchk++; if (ack !== 5'b0) begin nfail++; $display("FAIL bp_stall_ack%0d got=%b exp=0", c, ack); end
      nchk++; if (out_vld !== 1'b1 || out_src !== 5'b00010 || out_dir !== 5'b00100) begin nfail++; $display("FAIL bp_stall_out%0d got=%b/%b/%b exp=1/00010/00100", c, out_vld, out_src, out_dir); end
      nchk++; if (out_hdr !== mk(0, 8'h00, 0, 8'h02)) begin nfail++; $display("FAIL bp_stall_hdr%0d got=%h exp=%h", c, out_hdr, mk(0, 8'h00, 0, 8'h02)); end
      @(negedge clk);
    end
    out_rdy = 1'b1; #1;
    nchk++; if (ack !== 5'b00100) begin nfail++; $display("FAIL bp_release_ack got=%b exp=00100", ack); end
    @(negedge clk); req = '0; #1;
    nchk++; if (out_vld !== 1'b1 || out_src !== 5'b00100 || out_dir !== 5'b00010) begin nfail++; $display("FAIL bp_next_out got=%b/%b/%b exp=1/00100/00010", out_vld, out_src, out_dir); end
    nchk++; if (out_hdr !== mk(0, 8'h01, 0, 8'h00)) begin nfail++; $display("FAIL bp_next_hdr got=%h exp=%h", out_hdr, mk(0, 8'h01, 0, 8'h00)); end
    @(negedge clk); #1;
    nchk++; if (out_vld !== 1'b0) begin nfail++; $display("FAIL bp_drain got=%b exp=0", out_vld); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    req = 5'b01000; hdr[3*HW +: HW] = mk(0, 8'h00, 1, 8'h07); #1;
    nchk++; if (ack !== 5'b01000) begin nfail++; $display("FAIL mid_ack3 got=%b exp=01000", ack); end
    @(negedge clk);
    req = 5'b11110; rst = 1'b1; hdr[1*HW +: HW] = mk(0, 8'h00, 0, 8'h04); #1;
    nchk++; if (ack !== 5'b0) begin nfail++; $display("FAIL mid_rst_ack got=%b exp=0", ack); end
    @(negedge clk); #1;
    nchk++; if (out_vld !== 1'b0 || ack !== 5'b0) begin nfail++; $display("FAIL mid_rst_out got=%b/%b exp=0/0", out_vld, ack); end
    rst = 1'b0; #1;
    nchk++; if (ack !== 5'b00010) begin nfail++; $display("FAIL mid_ptr_reset got=%b exp=00010", ack); end
    @(negedge clk); req = '0; #1;
    nchk++; if (out_src !== 5'b00010 || out_dir !== 5'b00100) begin nfail++; $display("FAIL mid_out got=%b/%b exp=00010/00100", out_src, out_dir); end
    nchk++; if (out_hdr !== mk(0, 8'h00, 0, 8'h03)) begin nfail++; $display("FAIL mid_hdr got=%h exp=%h", out_hdr, mk(0, 8'h00, 0, 8'h03)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; hdr = '0; out_rdy = 1'b1;
    test_reset();
    test_east();
    test_back_to_back();
`ifdef RSCHED_LOCAL_PRIO_EN
    test_local_prio();
`else
    test_round_robin();
`endif
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
